// File: rtl/clock_pkg.sv
// Shared definitions for the alarm clock blocks.
//   alarm_state_t : alarm sequencer FSM encoding
//   DEF_MAX_*     : default minute/hour ranges
//   minute_t/hour_t : time field types sized for the default ranges
package clock_pkg;

    localparam int unsigned DEF_MAX_MINUTES = 60;
    localparam int unsigned DEF_MAX_HOURS   = 24;

    localparam int unsigned DEF_MIN_W  = $clog2(DEF_MAX_MINUTES);
    localparam int unsigned DEF_HOUR_W = $clog2(DEF_MAX_HOURS);

    typedef logic [DEF_MIN_W-1:0]  minute_t;
    typedef logic [DEF_HOUR_W-1:0] hour_t;

    typedef enum logic [1:0] {
        DISARMED = 2'd0,
        ARMED    = 2'd1,
        RINGING  = 2'd2,
        SNOOZE   = 2'd3
    } alarm_state_t;

endpackage : clock_pkg

// File: rtl/sec_counter.sv
// Seconds counter: counts tick pulses up to LIMIT and then holds there.
//   clk, rst  : clock, asynchronous active-low reset
//   clear     : synchronous clear, dominates tick
//   tick      : one-cycle count enable (tick_sec)
//   count     : current count, saturates at LIMIT
//   done      : registered terminal-count flag, high while count == LIMIT
module sec_counter #(
    parameter  int unsigned LIMIT = 60,
    localparam int unsigned CNT_W = $clog2(LIMIT + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             tick,
    output logic [CNT_W-1:0] count,
    output logic             done
);

    // Count with saturation; done rises together with the final increment.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
            done  <= 1'b0;
        end else if (clear) begin
            count <= '0;
            done  <= 1'b0;
        end else if (tick && !done) begin
            count <= count + CNT_W'(1);
            done  <= (count == CNT_W'(LIMIT - 1));
        end
    end

endmodule : sec_counter

// File: rtl/alarm_sequencer.sv
// Alarm sequencer: arms on set_alarm, rings when the running time reaches the
// armed time, supports stop, timed auto-stop and a limited number of snoozes.
// Optional feature macro: ALARM_SNOOZE_EN (snooze state and snooze budget).
//   clk, rst                   : clock, asynchronous active-low reset
//   tick_sec                   : one-cycle pulse per second
//   cur_minutes, cur_hours     : running time
//   alarm_minutes, alarm_hours : alarm setting, captured on set_alarm
//   set_alarm, alarm_enable    : capture-and-arm pulse, master enable level
//   stop_btn, snooze_btn       : debounced button levels
//   buzzer, ringing, snoozing, armed, snooze_left : registered status
module alarm_sequencer
    import clock_pkg::*;
#(
    parameter  int unsigned MAX_MINUTES    = DEF_MAX_MINUTES,
    parameter  int unsigned MAX_HOURS      = DEF_MAX_HOURS,
    parameter  int unsigned RING_TIMEOUT_S = 60,
    parameter  int unsigned SNOOZE_S       = 300,
    parameter  int unsigned MAX_SNOOZES    = 3,
    localparam int unsigned MIN_W          = $clog2(MAX_MINUTES),
    localparam int unsigned HOUR_W         = $clog2(MAX_HOURS),
    localparam int unsigned SL_W           = $clog2(MAX_SNOOZES + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              tick_sec,
    input  logic [MIN_W-1:0]  cur_minutes,
    input  logic [HOUR_W-1:0] cur_hours,
    input  logic [MIN_W-1:0]  alarm_minutes,
    input  logic [HOUR_W-1:0] alarm_hours,
    input  logic              set_alarm,
    input  logic              alarm_enable,
    input  logic              stop_btn,
    input  logic              snooze_btn,
    output logic              buzzer,
    output logic              ringing,
    output logic              snoozing,
    output logic              armed,
    output logic [SL_W-1:0]   snooze_left
);

    localparam int unsigned RING_W = $clog2(RING_TIMEOUT_S + 1);

    alarm_state_t      state;
    logic [MIN_W-1:0]  arm_min;
    logic [HOUR_W-1:0] arm_hour;
    logic              match_q;
    logic              stop_q;
    logic              match;
    logic              match_rise;
    logic              stop_edge;
    logic              snz_edge;
    logic              snooze_go;
    logic [RING_W-1:0] ring_cnt;
    logic              ring_done;
    logic              unused_cnt;

    // Alarm fires on the first cycle of a match only, against the latched setting.
    assign match      = (cur_minutes == arm_min) && (cur_hours == arm_hour);
    assign match_rise = match && !match_q;
    assign stop_edge  = stop_btn && !stop_q;

    // Ring timer runs only while ringing, so every entry starts from zero.
    sec_counter #(.LIMIT(RING_TIMEOUT_S)) u_ring_cnt (
        .clk   (clk),
        .rst   (rst),
        .clear (state != RINGING),
        .tick  (tick_sec),
        .count (ring_cnt),
        .done  (ring_done)
    );

`ifdef ALARM_SNOOZE_EN
    localparam int unsigned SNZ_W = $clog2(SNOOZE_S + 1);

    logic             snz_q;
    logic [SNZ_W-1:0] snz_cnt;
    logic             snz_done;

    assign snz_edge   = snooze_btn && !snz_q;
    assign snooze_go  = snz_edge && (snooze_left != '0);
    assign unused_cnt = (^ring_cnt) ^ (^snz_cnt);

    // Snooze timer runs only while snoozing.
    sec_counter #(.LIMIT(SNOOZE_S)) u_snz_cnt (
        .clk   (clk),
        .rst   (rst),
        .clear (state != SNOOZE),
        .tick  (tick_sec),
        .count (snz_cnt),
        .done  (snz_done)
    );

    // Snooze button history.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            snz_q <= 1'b0;
        end else begin
            snz_q <= snooze_btn;
        end
    end
`else
    logic unused_snooze;

    assign snz_edge      = 1'b0;
    assign snooze_go     = 1'b0;
    assign snoozing      = 1'b0;
    assign snooze_left   = '0;
    assign unused_cnt    = ^ring_cnt;
    assign unused_snooze = snooze_btn ^ (SNOOZE_S == 0);
`endif

    // Edge-detect history for the time match and the stop button.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            match_q <= 1'b0;
            stop_q  <= 1'b0;
        end else begin
            match_q <= match;
            stop_q  <= stop_btn;
        end
    end

    // Sequencer FSM: disable > set_alarm > stop > snooze > timeout/match.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= DISARMED;
            buzzer   <= 1'b0;
            ringing  <= 1'b0;
            armed    <= 1'b0;
            arm_min  <= '0;
            arm_hour <= '0;
`ifdef ALARM_SNOOZE_EN
            snoozing    <= 1'b0;
            snooze_left <= '0;
`endif
        end else if (!alarm_enable) begin
            state   <= DISARMED;
            buzzer  <= 1'b0;
            ringing <= 1'b0;
            armed   <= 1'b0;
`ifdef ALARM_SNOOZE_EN
            snoozing <= 1'b0;
`endif
        end else if (set_alarm) begin
            state    <= ARMED;
            buzzer   <= 1'b0;
            ringing  <= 1'b0;
            armed    <= 1'b1;
            arm_min  <= alarm_minutes;
            arm_hour <= alarm_hours;
`ifdef ALARM_SNOOZE_EN
            snoozing    <= 1'b0;
            snooze_left <= SL_W'(MAX_SNOOZES);
`endif
        end else begin
            case (state)
                ARMED: begin
                    if (match_rise) begin
                        state   <= RINGING;
                        buzzer  <= 1'b1;
                        ringing <= 1'b1;
                    end
                end
                RINGING: begin
`ifdef ALARM_SNOOZE_EN
                    if (!stop_edge && snooze_go) begin
                        state       <= SNOOZE;
                        buzzer      <= 1'b0;
                        ringing     <= 1'b0;
                        snoozing    <= 1'b1;
                        snooze_left <= snooze_left - SL_W'(1);
                    end else
`endif
                    // A snooze press with no budget left behaves like stop.
                    if (stop_edge || snz_edge || ring_done) begin
                        state   <= ARMED;
                        buzzer  <= 1'b0;
                        ringing <= 1'b0;
`ifdef ALARM_SNOOZE_EN
                        snooze_left <= SL_W'(MAX_SNOOZES);
`endif
                    end else if (tick_sec) begin
                        buzzer <= !buzzer;
                    end
                end
`ifdef ALARM_SNOOZE_EN
                SNOOZE: begin
                    if (stop_edge) begin
                        state       <= ARMED;
                        snoozing    <= 1'b0;
                        snooze_left <= SL_W'(MAX_SNOOZES);
                    end else if (snz_done) begin
                        state    <= RINGING;
                        buzzer   <= 1'b1;
                        ringing  <= 1'b1;
                        snoozing <= 1'b0;
                    end
                end
`endif
                default: begin
                end
            endcase
        end
    end

endmodule : alarm_sequencer

// File: tb/tb_alarm_sequencer.sv
// Directed self-checking bench for alarm_sequencer
// (RING_TIMEOUT_S=10, SNOOZE_S=5, MAX_SNOOZES=2). Snooze scenarios follow
// ALARM_SNOOZE_EN; without it the snooze button must have no effect.
module tb_alarm_sequencer;

    logic       clk;
    logic       rst;
    logic       tick_sec;
    logic [5:0] cur_minutes;
    logic [4:0] cur_hours;
    logic [5:0] alarm_minutes;
    logic [4:0] alarm_hours;
    logic       set_alarm;
    logic       alarm_enable;
    logic       stop_btn;
    logic       snooze_btn;
    logic       buzzer;
    logic       ringing;
    logic       snoozing;
    logic       armed;
    logic [1:0] snooze_left;

    int errors = 0;
    int checks = 0;

    alarm_sequencer #(
        .RING_TIMEOUT_S (10),
        .SNOOZE_S       (5),
        .MAX_SNOOZES    (2)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .tick_sec      (tick_sec),
        .cur_minutes   (cur_minutes),
        .cur_hours     (cur_hours),
        .alarm_minutes (alarm_minutes),
        .alarm_hours   (alarm_hours),
        .set_alarm     (set_alarm),
        .alarm_enable  (alarm_enable),
        .stop_btn      (stop_btn),
        .snooze_btn    (snooze_btn),
        .buzzer        (buzzer),
        .ringing       (ringing),
        .snoozing      (snoozing),
        .armed         (armed),
        .snooze_left   (snooze_left)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_tick();
        tick_sec = 1'b1;
        cyc(1);
        tick_sec = 1'b0;
    endtask

    task automatic set_time(input int h, input int m);
        cur_hours   = 5'(h);
        cur_minutes = 6'(m);
    endtask

    task automatic arm(input int h, input int m);
        alarm_hours   = 5'(h);
        alarm_minutes = 6'(m);
        set_alarm     = 1'b1;
        cyc(1);
        set_alarm     = 1'b0;
    endtask

    task automatic press_stop();
        stop_btn = 1'b1;
        cyc(1);
        stop_btn = 1'b0;
        cyc(1);
    endtask

    // Leave 07:30 and come back to it, producing a fresh match edge.
    task automatic reach_0730();
        set_time(7, 29);
        cyc(1);
        set_time(7, 30);
        cyc(1);
    endtask

    task automatic test_reset();
        cyc(3);
        checks++;
        if ({buzzer, ringing, snoozing, armed, snooze_left} !== 6'b0) begin
            errors++;
            $display("FAIL reset_outputs: got %b expected 000000",
                     {buzzer, ringing, snoozing, armed, snooze_left});
        end
        rst = 1'b1;
        cyc(2);
        checks++;
        if (armed !== 1'b0 || ringing !== 1'b0) begin
            errors++;
            $display("FAIL post_reset_disarmed: armed=%b ringing=%b expected 0 0", armed, ringing);
        end
    endtask

    task automatic test_ring_timeout();
        set_time(7, 29);
        arm(7, 30);
        checks++;
        if (armed !== 1'b1 || ringing !== 1'b0) begin
            errors++;
            $display("FAIL arm: armed=%b ringing=%b expected 1 0", armed, ringing);
        end
`ifdef ALARM_SNOOZE_EN
        checks++;
        if (snooze_left !== 2'd2) begin
            errors++;
            $display("FAIL arm_snooze_left: got %0d expected 2", snooze_left);
        end
`endif
        cyc(2);
        set_time(7, 30);
        checks++;
        if (ringing !== 1'b0) begin
            errors++;
            $display("FAIL ring_not_early: ringing=%b expected 0", ringing);
        end
        cyc(1);
        checks++;
        if (ringing !== 1'b1 || buzzer !== 1'b1) begin
            errors++;
            $display("FAIL ring_entry: ringing=%b buzzer=%b expected 1 1", ringing, buzzer);
        end
        for (int k = 1; k <= 9; k++) begin
            pulse_tick();
            checks++;
            if (ringing !== 1'b1 || buzzer !== ((k % 2) == 0)) begin
                errors++;
                $display("FAIL buzzer_tick%0d: ringing=%b buzzer=%b expected 1 %0d",
                         k, ringing, buzzer, ((k % 2) == 0));
            end
        end
        pulse_tick();
        cyc(1);
        checks++;
        if (ringing !== 1'b0 || armed !== 1'b1 || buzzer !== 1'b0) begin
            errors++;
            $display("FAIL ring_timeout: ringing=%b armed=%b buzzer=%b expected 0 1 0",
                     ringing, armed, buzzer);
        end
        cyc(3);
        checks++;
        if (ringing !== 1'b0) begin
            errors++;
            $display("FAIL timeout_no_retrigger: ringing=%b expected 0", ringing);
        end
    endtask

    task automatic test_stop();
        reach_0730();
        checks++;
        if (ringing !== 1'b1) begin
            errors++;
            $display("FAIL stop_setup_ring: ringing=%b expected 1", ringing);
        end
        stop_btn = 1'b1;
        cyc(1);
        checks++;
        if (ringing !== 1'b0 || armed !== 1'b1 || buzzer !== 1'b0) begin
            errors++;
            $display("FAIL stop: ringing=%b armed=%b buzzer=%b expected 0 1 0",
                     ringing, armed, buzzer);
        end
        cyc(3);
        pulse_tick();
        pulse_tick();
        checks++;
        if (ringing !== 1'b0 || armed !== 1'b1) begin
            errors++;
            $display("FAIL stop_held: ringing=%b armed=%b expected 0 1", ringing, armed);
        end
        stop_btn = 1'b0;
        cyc(1);
        set_time(7, 31);
        cyc(1);
        set_time(12, 0);
        cyc(1);
        set_time(7, 30);
        cyc(1);
        checks++;
        if (ringing !== 1'b1) begin
            errors++;
            $display("FAIL next_day_ring: ringing=%b expected 1", ringing);
        end
        press_stop();
    endtask

    task automatic test_armed_regs();
        set_time(5, 59);
        arm(6, 0);
        alarm_hours   = 5'd9;
        alarm_minutes = 6'd15;
        cyc(1);
        set_time(9, 15);
        cyc(3);
        checks++;
        if (ringing !== 1'b0) begin
            errors++;
            $display("FAIL unlatched_setting: ringing=%b expected 0", ringing);
        end
        set_time(6, 0);
        cyc(1);
        checks++;
        if (ringing !== 1'b1) begin
            errors++;
            $display("FAIL latched_setting: ringing=%b expected 1", ringing);
        end
        press_stop();
        set_time(7, 29);
        arm(7, 30);
    endtask

`ifdef ALARM_SNOOZE_EN
    task automatic test_snooze();
        reach_0730();
        for (int n = 0; n < 2; n++) begin
            snooze_btn = 1'b1;
            cyc(1);
            snooze_btn = 1'b0;
            checks++;
            if (snoozing !== 1'b1 || ringing !== 1'b0 || buzzer !== 1'b0 ||
                snooze_left !== 2'(1 - n)) begin
                errors++;
                $display("FAIL snooze%0d_enter: snoozing=%b ringing=%b buzzer=%b left=%0d expected 1 0 0 %0d",
                         n, snoozing, ringing, buzzer, snooze_left, 1 - n);
            end
            repeat (4) pulse_tick();
            checks++;
            if (snoozing !== 1'b1) begin
                errors++;
                $display("FAIL snooze%0d_hold: snoozing=%b expected 1", n, snoozing);
            end
            pulse_tick();
            cyc(1);
            checks++;
            if (ringing !== 1'b1 || snoozing !== 1'b0 || buzzer !== 1'b1) begin
                errors++;
                $display("FAIL snooze%0d_rering: ringing=%b snoozing=%b buzzer=%b expected 1 0 1",
                         n, ringing, snoozing, buzzer);
            end
        end
        snooze_btn = 1'b1;
        cyc(1);
        snooze_btn = 1'b0;
        checks++;
        if (ringing !== 1'b0 || snoozing !== 1'b0 || armed !== 1'b1 || snooze_left !== 2'd2) begin
            errors++;
            $display("FAIL snooze_exhausted: ringing=%b snoozing=%b armed=%b left=%0d expected 0 0 1 2",
                     ringing, snoozing, armed, snooze_left);
        end
        cyc(1);
    endtask
`else
    task automatic test_no_snooze();
        reach_0730();
        snooze_btn = 1'b1;
        cyc(3);
        checks++;
        if (ringing !== 1'b1 || snoozing !== 1'b0 || snooze_left !== 2'd0) begin
            errors++;
            $display("FAIL snooze_ignored: ringing=%b snoozing=%b left=%0d expected 1 0 0",
                     ringing, snoozing, snooze_left);
        end
        snooze_btn = 1'b0;
        press_stop();
    endtask
`endif

    task automatic test_back_to_back();
        reach_0730();
        arm(7, 30);
        checks++;
        if (ringing !== 1'b0 || armed !== 1'b1) begin
            errors++;
            $display("FAIL set_during_ring: ringing=%b armed=%b expected 0 1", ringing, armed);
        end
        cyc(3);
        checks++;
        if (ringing !== 1'b0) begin
            errors++;
            $display("FAIL set_during_match: ringing=%b expected 0", ringing);
        end
    endtask

    task automatic test_disable();
        reach_0730();
`ifdef ALARM_SNOOZE_EN
        snooze_btn = 1'b1;
        cyc(1);
        snooze_btn = 1'b0;
        checks++;
        if (snoozing !== 1'b1) begin
            errors++;
            $display("FAIL disable_setup_snooze: snoozing=%b expected 1", snoozing);
        end
`endif
        alarm_enable = 1'b0;
        cyc(1);
        checks++;
        if (armed !== 1'b0 || ringing !== 1'b0 || snoozing !== 1'b0 || buzzer !== 1'b0) begin
            errors++;
            $display("FAIL disable: armed=%b ringing=%b snoozing=%b buzzer=%b expected 0 0 0 0",
                     armed, ringing, snoozing, buzzer);
        end
        arm(7, 30);
        checks++;
        if (armed !== 1'b0) begin
            errors++;
            $display("FAIL set_while_disabled: armed=%b expected 0", armed);
        end
        alarm_enable = 1'b1;
        cyc(1);
        reach_0730();
        cyc(1);
        checks++;
        if (armed !== 1'b0 || ringing !== 1'b0) begin
            errors++;
            $display("FAIL reenable_no_arm: armed=%b ringing=%b expected 0 0", armed, ringing);
        end
    endtask

    task automatic test_reset_mid_ring();
        set_time(7, 29);
        arm(7, 30);
        reach_0730();
        checks++;
        if (ringing !== 1'b1) begin
            errors++;
            $display("FAIL rst_setup_ring: ringing=%b expected 1", ringing);
        end
        #5;
        rst = 1'b0;
        #1;
        checks++;
        if ({buzzer, ringing, snoozing, armed, snooze_left} !== 6'b0) begin
            errors++;
            $display("FAIL async_reset: got %b expected 000000",
                     {buzzer, ringing, snoozing, armed, snooze_left});
        end
        cyc(2);
        rst = 1'b1;
        cyc(1);
        reach_0730();
        cyc(2);
        checks++;
        if (ringing !== 1'b0 || armed !== 1'b0) begin
            errors++;
            $display("FAIL ring_after_reset: ringing=%b armed=%b expected 0 0", ringing, armed);
        end
    endtask

    initial begin
        rst           = 1'b0;
        tick_sec      = 1'b0;
        cur_minutes   = '0;
        cur_hours     = '0;
        alarm_minutes = '0;
        alarm_hours   = '0;
        set_alarm     = 1'b0;
        alarm_enable  = 1'b1;
        stop_btn      = 1'b0;
        snooze_btn    = 1'b0;

        test_reset();
        test_ring_timeout();
        test_stop();
        test_armed_regs();
`ifdef ALARM_SNOOZE_EN
        test_snooze();
`else
        test_no_snooze();
`endif
        test_back_to_back();
        test_disable();
        test_reset_mid_ring();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_alarm_sequencer

// File: doc/alarm_sequencer.md
ALARM_SEQUENCER -- requirements
Module: alarm_sequencer

Interface
REQ-001 Parameter MAX_MINUTES, default 60, minutes per hour.
REQ-002 Parameter MAX_HOURS, default 24, hours per day.
REQ-003 Parameter RING_TIMEOUT_S, default 60, seconds of ringing before auto-stop.
REQ-004 Parameter SNOOZE_S, default 300, snooze length in seconds.
REQ-005 Parameter MAX_SNOOZES, default 3, snoozes allowed per alarm event.
REQ-006 Ports, in order: clk in 1, 50 MHz clock; rst in 1, reset. One clock; reset is asynchronous and active-low.
REQ-007 tick_sec in 1, one-cycle pulse once per second.
REQ-008 cur_minutes in $clog2(MAX_MINUTES), cur_hours in $clog2(MAX_HOURS): running time.
REQ-009 alarm_minutes in $clog2(MAX_MINUTES), alarm_hours in $clog2(MAX_HOURS): alarm setting from settings controller.
REQ-010 set_alarm in 1, pulse: capture alarm setting and arm; alarm_enable in 1, level: master enable.
REQ-011 stop_btn in 1, snooze_btn in 1: debounced active-high levels.
REQ-012 Outputs: buzzer 1; ringing 1; snoozing 1; armed 1; snooze_left $clog2(MAX_SNOOZES+1).

Function
REQ-013 SHALL implement FSM states DISARMED, ARMED, RINGING, SNOOZE.
REQ-014 SHALL rising-edge detect stop_btn and snooze_btn internally; a held button acts once.
REQ-015 set_alarm with alarm_enable=1 SHALL latch alarm_minutes/hours into armed registers, load snooze_left=MAX_SNOOZES, go to ARMED from any state, next cycle.
REQ-016 set_alarm with alarm_enable=0 SHALL be ignored.
REQ-017 alarm_enable=0 SHALL force DISARMED next cycle from any state; highest priority after reset.
REQ-018 ARMED -> RINGING on the cycle after cur time first equals armed time (rising edge of match); staying matched SHALL NOT retrigger, so stop within the matching minute holds ARMED.
REQ-019 RINGING: buzzer starts 1 on entry, toggles on each tick_sec; ring_cnt counts tick_sec; at RING_TIMEOUT_S ticks -> ARMED, snooze_left reloaded.
REQ-020 RINGING: stop edge -> ARMED, snooze_left reloaded; snooze edge with snooze_left>0 -> SNOOZE, snooze_left decremented; snooze edge with snooze_left=0 treated as stop.
REQ-021 SNOOZE: buzzer 0; snz_cnt counts tick_sec; at SNOOZE_S ticks -> RINGING with ring_cnt cleared; stop edge -> ARMED, snooze_left reloaded; snooze edge ignored.
REQ-022 Same-cycle priority: alarm_enable=0 > set_alarm > stop > snooze > timeout/match.
REQ-023 Counters SHALL be sized $clog2(max+1), saturate never exceed limit, clear on every state entry.
REQ-024 ringing=(state==RINGING), snoozing=(state==SNOOZE), armed=(state!=DISARMED); all registered.
REQ-025 Comparison SHALL use armed registers only; later alarm_minutes/hours changes without set_alarm have no effect.

Reset
REQ-026 rst low SHALL asynchronously force DISARMED, buzzer/ringing/snoozing/armed 0, snooze_left 0, counters, armed registers and edge-detect history 0.
REQ-027 Reset released mid-ringing SHALL resume in DISARMED; no ring until new set_alarm.

Configuration
REQ-028 Macro ALARM_SNOOZE_EN defined: snooze behaviour per REQ-020/021.
REQ-029 ALARM_SNOOZE_EN undefined: SNOOZE state, snz_cnt, snooze_left logic omitted; snooze_btn ignored; snoozing and snooze_left tied 0.

Structure
REQ-030 Shared package clock_pkg SHALL hold alarm_state_t enum, MAX_MINUTES/MAX_HOURS defaults, minute/hour width typedefs.
REQ-031 Sub-module sec_counter (tick_sec-driven counter with clear, terminal-count flag) SHALL be instantiated for ring and snooze timing.

Verification (RING_TIMEOUT_S=10, SNOOZE_S=5, MAX_SNOOZES=2)
REQ-032 set_alarm with 07:30, run time 07:29->07:30 -> ringing=1 cycle after match, buzzer 1,0,1... per tick_sec; after 10 ticks ringing=0, armed=1.
REQ-033 Ringing, stop_btn pressed and held at 07:30 -> ARMED, no retrigger while held or during 07:30; rings next day 07:30.
REQ-034 Ringing, snooze x2 each followed by 5 ticks -> snoozing 5 s then ringing again, snooze_left 2->1->0; third snooze -> ARMED.
REQ-035 alarm_enable dropped during SNOOZE -> DISARMED next cycle; set_alarm with enable=0 -> stays DISARMED.
REQ-036 Assert rst low mid-RINGING -> all outputs 0 immediately; after release, matching time produces no ring.
REQ-037 Build without ALARM_SNOOZE_EN: snooze_btn during ringing -> no state change, snoozing stays 0.
